// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt vector responder.
//   state_e      : responder FSM states
//   LVL_W        : width of an interrupt level (8 levels)
//   vec_addr()   : vector byte for a level, wrapping modulo 256
package irq_pkg;

  localparam int LVL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_ACK  = 3'd2,
    ST_CLR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // Vector = base + level * 2^sh; the 8-bit result wraps naturally.
  function automatic logic [7:0] vec_addr(input logic [7:0]       base,
                                          input logic [LVL_W-1:0] lvl,
                                          input int unsigned      sh);
    logic [7:0] offs;
    offs = {5'b00000, lvl} << sh;
    return base + offs;
  endfunction

endpackage

// File: rtl/irq_level_decoder.sv
// 3-to-8 one-hot decoder with enable.
//   en_i     : when low the output is all zeros
//   lvl_i    : level to decode
//   onehot_o : one-hot of lvl_i when enabled
module irq_level_decoder
  import irq_pkg::*;
(
  input  logic             en_i,
  input  logic [LVL_W-1:0] lvl_i,
  output logic [7:0]       onehot_o
);

  assign onehot_o = en_i ? (8'b0000_0001 << lvl_i) : 8'h00;

endmodule

// File: rtl/irq_vector_responder.sv
// Interrupt vector responder for a Z80-style CPU interrupt acknowledge.
// Raises int_n on a pending request, supplies the vector byte during the
// M1+IORQ acknowledge, then pulses a clear to the serviced source and
// keeps int_n high for one further gap cycle.
//   clk_sys  : clock              reset   : synchronous, active-high
//   enc_q    : active-low level   enc_gs  : active-low group select
//   int_en   : global enable      vec_base: vector table base
//   m1_n     : CPU M1 (low)       iorq_n  : CPU IORQ (low)
//   int_n    : interrupt request to CPU (active-low)
//   dout     : vector byte        dout_oe : dout drives the data bus
//   src_clr  : one-hot, one-cycle clear to the serviced source
//   busy     : FSM not idle
module irq_vector_responder
  import irq_pkg::*;
#(
  parameter int unsigned VEC_SHIFT = 1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [2:0] enc_q,
  input  logic       enc_gs,
  input  logic       int_en,
  input  logic [7:0] vec_base,
  input  logic       m1_n,
  input  logic       iorq_n,
  output logic       int_n,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic [7:0] src_clr,
  output logic       busy
);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [7:0]       dout_q, dout_d;
  logic             ack;

  assign ack = !m1_n && !iorq_n;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        dout_d = 8'h00;
        if (!enc_gs && int_en) state_d = ST_PEND;
      end
      ST_PEND: begin
        // Withdrawal wins over a simultaneous acknowledge.
        if (enc_gs || !int_en) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          lvl_d   = ~enc_q;
          dout_d  = vec_addr(vec_base, ~enc_q, VEC_SHIFT);
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Level and vector are frozen here; only the end of ack matters.
        if (!ack) begin
          dout_d  = 8'h00;
          state_d = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        dout_d  = 8'h00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs are registers or decodes of registered state.
  assign int_n   = !(state_q == ST_PEND || state_q == ST_ACK);
  assign dout_oe = (state_q == ST_ACK);
  assign dout    = dout_q;
  assign busy    = (state_q != ST_IDLE);

  irq_level_decoder u_dec (
    .en_i     (state_q == ST_CLR),
    .lvl_i    (lvl_q),
    .onehot_o (src_clr)
  );

endmodule

// File: tb/tb_irq_vector_responder.sv
module tb_irq_vector_responder;

  localparam int unsigned SH = 1;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [2:0] enc_q;
  logic       enc_gs;
  logic       int_en;
  logic [7:0] vec_base;
  logic       m1_n;
  logic       iorq_n;
  logic       int_n;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] src_clr;
  logic       busy;

  always #5 clk_sys = ~clk_sys;

  irq_vector_responder #(.VEC_SHIFT(SH)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .enc_q    (enc_q),
    .enc_gs   (enc_gs),
    .int_en   (int_en),
    .vec_base (vec_base),
    .m1_n     (m1_n),
    .iorq_n   (iorq_n),
    .int_n    (int_n),
    .dout     (dout),
    .dout_oe  (dout_oe),
    .src_clr  (src_clr),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the CPU and the sources should observe.
  bit m_requesting;   // int_n asserted, waiting for acknowledge
  bit m_serving;      // vector on the bus
  bit m_clearing;     // clear pulse to the source
  bit m_gap;          // mandatory quiet cycle
  int m_lvl;
  int m_vec;
  int clr_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int vec_of(input int base, input int lvl);
    return (base + lvl * (1 << SH)) % 256;
  endfunction

  task automatic model_step();
    bit ack;
    ack = (m1_n == 1'b0) && (iorq_n == 1'b0);
    if (reset) begin
      m_requesting = 0; m_serving = 0; m_clearing = 0; m_gap = 0; m_lvl = 0;
    end else if (m_serving) begin
      if (!ack) begin m_serving = 0; m_clearing = 1; end
    end else if (m_clearing) begin
      m_clearing = 0; m_gap = 1;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_requesting) begin
      if (enc_gs || !int_en) m_requesting = 0;
      else if (ack) begin
        m_requesting = 0;
        m_serving    = 1;
        m_lvl        = 7 - int'(enc_q);
        m_vec        = vec_of(int'(vec_base), m_lvl);
      end
    end else if (!enc_gs && int_en) begin
      m_requesting = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("int_n",   int_n,   !(m_requesting || m_serving));
    check_eq("dout",    dout,    m_serving ? m_vec : 0);
    check_eq("dout_oe", dout_oe, m_serving);
    check_eq("src_clr", src_clr, m_clearing ? (32'd1 << m_lvl) : 0);
    check_eq("busy",    busy,    m_requesting || m_serving || m_clearing || m_gap);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    compare_all();
    if (src_clr != 8'h00) clr_seen++;
  endtask

  task automatic drive(input bit gs, input logic [2:0] q, input bit en,
                       input logic [7:0] base, input bit ack);
    enc_gs = gs; enc_q = q; int_en = en; vec_base = base;
    m1_n = !ack; iorq_n = !ack;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1, 3'b000, 0, 8'h00, 0);
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_int_n", int_n, 1);
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_busy", busy, 0);
    tick();

    // Level 5 service, ack held three cycles.
    drive(0, 3'b010, 1, 8'hE0, 0); tick();
    check_eq("l5_int_low", int_n, 0);
    drive(0, 3'b010, 1, 8'hE0, 1); tick();
    check_eq("l5_vec_c1", dout, 8'hEA); check_eq("l5_oe_c1", dout_oe, 1);
    tick();
    check_eq("l5_vec_c2", dout, 8'hEA); check_eq("l5_oe_c2", dout_oe, 1);
    tick();
    check_eq("l5_vec_c3", dout, 8'hEA); check_eq("l5_oe_c3", dout_oe, 1);
    drive(1, 3'b010, 1, 8'hE0, 0); tick();
    check_eq("l5_clr", src_clr, 8'h20); check_eq("l5_oe_off", dout_oe, 0);
    check_eq("l5_int_h1", int_n, 1);
    tick();
    check_eq("l5_clr_once", src_clr, 8'h00); check_eq("l5_int_h2", int_n, 1);
    tick();
    check_eq("l5_idle", busy, 0);

    // Request withdrawn before acknowledge.
    clr_seen = 0;
    drive(0, 3'b100, 1, 8'h10, 0); tick();
    check_eq("wd_int_low", int_n, 0);
    drive(1, 3'b100, 1, 8'h10, 0); tick();
    check_eq("wd_int_high", int_n, 1); check_eq("wd_busy", busy, 0);
    tick(); tick();
    check_eq("wd_no_clr", clr_seen, 0);

    // Vector wrap-around at level 7.
    drive(0, 3'b000, 1, 8'hFC, 0); tick();
    drive(0, 3'b000, 1, 8'hFC, 1); tick();
    check_eq("wrap_vec", dout, 8'h0A);
    drive(1, 3'b000, 1, 8'hFC, 0); tick(); tick(); tick();

    // Level freezes during ACK even when the encoder changes.
    drive(0, 3'b000, 1, 8'h40, 0); tick();
    drive(0, 3'b000, 1, 8'h40, 1); tick();
    drive(0, 3'b111, 1, 8'h40, 1); tick();
    check_eq("frz_vec", dout, 8'h4E);
    drive(1, 3'b111, 0, 8'h40, 1); tick();
    check_eq("frz_vec2", dout, 8'h4E);
    drive(1, 3'b111, 0, 8'h40, 0); tick();
    check_eq("frz_clr", src_clr, 8'h80);
    tick(); tick();

    // Reset in the second ACK cycle.
    drive(0, 3'b011, 1, 8'h20, 0); tick();
    drive(0, 3'b011, 1, 8'h20, 1); tick(); tick();
    check_eq("rs_in_ack", dout_oe, 1);
    reset = 1'b1; tick();
    check_eq("rs_oe", dout_oe, 0); check_eq("rs_int", int_n, 1);
    check_eq("rs_clr", src_clr, 8'h00);
    reset = 1'b0; clr_seen = 0;
    drive(1, 3'b011, 1, 8'h20, 0); tick(); tick(); tick();
    check_eq("rs_no_clr", clr_seen, 0);

    // Disabled: acknowledge is ignored.
    drive(0, 3'b001, 0, 8'h30, 0); tick();
    drive(0, 3'b001, 0, 8'h30, 1); tick();
    check_eq("dis_int", int_n, 1); check_eq("dis_oe", dout_oe, 0);
    tick(); tick();
    check_eq("dis_oe2", dout_oe, 0);
    drive(1, 3'b001, 0, 8'h30, 0); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      enc_gs   = ($urandom_range(0, 9) < 3);
      enc_q    = 3'($urandom_range(0, 7));
      int_en   = ($urandom_range(0, 9) < 9);
      vec_base = 8'($urandom_range(0, 255));
      m1_n     = ($urandom_range(0, 9) < 5);
      iorq_n   = ($urandom_range(0, 9) < 4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
